// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the future
// transmit path.
//   DATA_BITS  - payload bits per frame (8N1 framing)
//   rx_state_t - receiver FSM states
//   baud_div() - clocks per bit, rounded to the nearest integer
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   i_push, i_wdata   - write request and data
//   i_pop             - read request; the head advances at this edge
//   o_rdata           - word at the head (don't-care while empty)
//   o_full, o_empty   - occupancy flags
//   o_count           - current occupancy, 0..DEPTH
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. A pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO with a valid/ready
// output stream and sticky framing/overrun flags.
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   rx                  - asynchronous serial input, idles high
//   rx_data, rx_valid   - FIFO head byte, FIFO not empty
//   rx_ready            - consumer takes rx_data this cycle
//   count               - FIFO occupancy
//   frame_err, overrun  - sticky error flags
//   err_clr             - synchronous clear of both flags (a set wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        err_clr
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(DIV - 1);

  if (DIV < 16) begin : g_div_check
    $error("uart_rx_fifo: clocks per bit must be at least 16");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic                  r_sync1;
  logic                  r_rxs;
  rx_state_t             r_state;
  rx_state_t             w_next;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [2:0]            r_bitidx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_armed;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic                  w_sample;
  logic                  w_ld_half;
  logic                  w_ld_full;
  logic                  w_shift;
  logic                  w_push;
  logic                  w_frame_set;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_overrun_set;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  assign w_sample = (r_bitcnt == '0);

  always_comb begin
    w_next      = r_state;
    w_ld_half   = 1'b0;
    w_ld_full   = 1'b0;
    w_shift     = 1'b0;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
    case (r_state)
      IDLE: begin
        // Only a genuine high-to-low transition starts a frame.
        if (r_armed && !r_rxs) begin
          w_next    = START;
          w_ld_half = 1'b1;
        end
      end
      START: begin
        if (w_sample) begin
          if (!r_rxs) begin
            w_next    = DATA;
            w_ld_full = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      DATA: begin
        if (w_sample) begin
          w_shift   = 1'b1;
          w_ld_full = 1'b1;
          if (r_bitidx == 3'(DATA_BITS - 1)) w_next = STOP;
        end
      end
      STOP: begin
        // Return to IDLE at mid-stop-bit so back-to-back frames are caught.
        if (w_sample) begin
          w_next = IDLE;
          if (r_rxs) w_push      = 1'b1;
          else       w_frame_set = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_bitidx <= '0;
      r_shift  <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_ld_half)          r_bitcnt <= HALF_LD;
      else if (w_ld_full)     r_bitcnt <= FULL_LD;
      else if (!w_sample)     r_bitcnt <= r_bitcnt - CNT_W'(1);

      if (r_state == START)   r_bitidx <= '0;
      else if (w_shift)       r_bitidx <= r_bitidx + 3'd1;

      if (w_shift)            r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};

      // After a bad stop bit the line may still be low; wait for it to go
      // high before another start can be recognised.
      if (w_frame_set)        r_armed <= 1'b0;
      else if (r_rxs)         r_armed <= 1'b1;
    end
  end

  assign w_pop         = !w_empty && rx_ready;
  assign w_overrun_set = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_frame_set)        r_frame_err <= 1'b1;
      else if (err_clr)       r_frame_err <= 1'b0;

      if (w_overrun_set)      r_overrun <= 1'b1;
      else if (err_clr)       r_overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_rdata (rx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  assign rx_valid  = !w_empty;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Hardware UART receiver with a byte FIFO. It sits directly behind the board `RsRx` pin and in front of the on-chip command consumer, such as the MicroBlaze MCS GPIO path or a future hardware command decoder. The block deserialises 8N1 frames, checks the stop bit and buffers received bytes. It hands them downstream on a valid/ready stream and reports framing and overrun errors.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency in Hz.
- `BAUD`, 115200, line rate. `DIV = (CLK_HZ + BAUD/2) / BAUD` clocks per bit, which is 868 at the defaults. `DIV >= 16` is required, so elaboration fails otherwise.
- `DEPTH`, 16, FIFO depth in bytes. Must be a power of two and at least 2.

Ports:
- `clk`, in, 1, system clock. All logic is on the rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `rx`, in, 1, asynchronous serial line; idles high.
- `rx_data`, out, 8, byte at the FIFO head.
- `rx_valid`, out, 1, FIFO is not empty.
- `rx_ready`, in, 1, consumer accepts `rx_data` this cycle.
- `count`, out, `$clog2(DEPTH+1)`, current FIFO occupancy.
- `frame_err`, out, 1, sticky flag: a frame was received with stop bit = 0.
- `overrun`, out, 1, sticky flag: a byte was dropped because the FIFO was full.
- `err_clr`, in, 1, synchronous clear of both sticky flags.

## Operation
- **Input synchroniser.** `rx` passes through a 2-flop synchroniser; both flops reset to 1. All decisions use the synchronised value `rxs`.
- **Bit counter.** `bitcnt` is a down-counter of width `$clog2(DIV)`. A sample occurs when it reaches 0.
- **IDLE.** When `rxs == 0`, load `bitcnt = DIV/2 - 1` and go to START.
- **START.** At the sample:
  - if `rxs == 0`, load `DIV - 1`, clear the bit index, go to DATA;
  - if `rxs == 1`, the start was a glitch: go to IDLE with no flags set.
- **DATA.** At each sample, shift `rxs` into the shift register LSB-first and reload `DIV - 1`. After the 8th bit, go to STOP.
- **STOP.** At the sample, go to IDLE. This is a mid-stop-bit return, which allows back-to-back frames and baud-rate slack.
  - If `rxs == 1`: push the byte. If the FIFO is full and no pop happens this cycle, drop the byte and set `overrun`.
  - If `rxs == 0`: discard the byte and set `frame_err`. A line held low then re-triggers START only after `rxs` returns high and falls again. The IDLE entry condition for this case is "rxs high seen".
- **FIFO.** Show-ahead:
  - `rx_data = mem[rd_ptr]`; `rx_valid = (count != 0)`.
  - Pop occurs when `rx_valid && rx_ready`.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
  - A push into a full FIFO is accepted only if a pop occurs in the same cycle; `count` then stays unchanged.
  - A push and pop together when empty is impossible, because `rx_valid = 0`.
  - `rx_data` is don't-care while `rx_valid = 0`.
- **Error flags.**
  - `frame_err` and `overrun` set on their events and hold until `err_clr`.
  - If a set event and `err_clr` occur in the same cycle, set wins.
- **Reset values.** The following hold during and immediately after reset:
  - state = IDLE, `rx_valid = 0`, `count = 0`, `frame_err = 0`, `overrun = 0`;
  - shift register and pointers = 0; FIFO memory contents are not reset.
- **Reset mid-frame.** Reset aborts the frame. No partial byte is pushed, and the receiver resynchronises on the next falling edge that follows line idle.

## Timing
- **Start detection.** The falling edge at the `rx` pin reaches `rxs` after 2 clocks.
- **Sample points.**
  - Start-bit sample: `DIV/2` clocks after the IDLE→START transition.
  - Data bit k (k = 0..7): `DIV/2 + (k+1)*DIV` clocks after that transition.
  - Stop-bit sample: `DIV/2 + 9*DIV` clocks after that transition.
- **Pin-to-stream latency.** The byte is written at the stop-sample edge. `rx_valid` rises on the next cycle, so latency from the pin falling edge is about `2 + DIV/2 + 9*DIV + 1` clocks.
- **Flag timing.** `frame_err` and `overrun` assert one cycle after the stop-sample edge.
- **Handshake.**
  - Pop takes effect at the clock edge where `rx_valid && rx_ready`.
  - The next byte is presented in the following cycle, so sustained throughput is 1 byte/clock from the FIFO.
  - `rx_ready` may be held high permanently.
- **Tolerance.** Mid-bit sampling tolerates about ±4% total baud mismatch.

## Structure
- **Package `uart_pkg`:**
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`;
  - constant function `baud_div(clk_hz, baud)`;
  - `localparam` for data bits (8), shared with a later transmitter.
- **Sub-module `sync_fifo`** (parameters `WIDTH`, `DEPTH`), reusable by the future TX path. It provides push, pop, full, empty and count.
- **Top `uart_rx_fifo`** contains the synchroniser, the bit counter and FSM, the error flags, and one `sync_fifo` instance.

## Test plan
- **Single byte.** Reset, then send 0xA5 at `DIV = 16` (test override) with `rx_ready = 0`. Required: `rx_valid` rises at the computed cycle, `rx_data = 0xA5`, `count = 1`, no flags. Raise `rx_ready` for 1 cycle: `rx_valid = 0`, `count = 0`.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x55 with no idle gap. Required: popped in order, no `frame_err`.
- **Framing error.** Send 0x3C with stop bit = 0. Required: no push, `frame_err = 1` and it stays 1. Next good byte 0x12 is received normally. Pulse `err_clr`: flag = 0.
- **Overrun at full.** Fill with DEPTH bytes (0x01..0x10), `rx_ready = 0`. Required: `count = 16` and the 17th byte sets `overrun`. Drain: 0x01..0x10 in order. Repeat with `rx_ready` pulsed on the 17th push cycle: no `overrun`, and `count` stays 16.
- **Glitch rejection.** Drive a low pulse of `DIV/4` clocks. Required: return to IDLE, no push, no flags.
- **Reset mid-frame.** Assert `rst_n` low during data bit 4 for 3 clocks, then send 0x7E after 2 bit-times of idle. Required: only 0x7E is received.
